// File: rtl/acum_potencia_pkg.sv
// potencia_pkg: shared defaults and helpers for the switching-power accumulator.
//   - default widths for the accumulator parameters
//   - W_IDX_DEF: group index width derived from the default group count
//   - sat_add(): unsigned add that clamps to a runtime width and flags overflow
package potencia_pkg;

  localparam int N_CH_DEF   = 8;
  localparam int N_GRP_DEF  = 4;
  localparam int W_PESO_DEF = 4;
  localparam int W_ACC_DEF  = 16;
  localparam int W_IDX_DEF  = $clog2(N_GRP_DEF);

  // Widest accumulator sat_add can handle; callers zero-extend into it.
  localparam int W_SAT_MAX = 32;

  // Returns {overflow, clamped_sum}. The sum is clamped to 2^w-1 and the
  // overflow bit is set whenever the true sum exceeded that limit.
  function automatic logic [W_SAT_MAX:0] sat_add(
    input logic [W_SAT_MAX-1:0] a,
    input logic [W_SAT_MAX-1:0] b,
    input int unsigned          w
  );
    logic [W_SAT_MAX:0] s;
    logic [W_SAT_MAX:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = ((W_SAT_MAX+1)'(1) << w) - (W_SAT_MAX+1)'(1);
    if (s > lim) sat_add = {1'b1, W_SAT_MAX'(lim)};
    else         sat_add = {1'b0, W_SAT_MAX'(s)};
  endfunction

endpackage

// File: rtl/acum_potencia_if.sv
// acum_potencia_if: group read port of the power accumulator.
//   rd_req   : read request (master -> slave), may be asserted every cycle
//   rd_grp   : group to read, sampled with rd_req
//   rd_valid : one-cycle pulse, the edge after an accepted rd_req
//   rd_dato  : group total as it was before the request edge
//   rd_sat   : group saturated since its last clear
// Handshake: there is no backpressure. Every rd_req sampled high at edge r is
// answered by rd_valid high for exactly the cycle after r; rd_dato/rd_sat hold
// their last values while rd_valid is low.
interface acum_potencia_if
  import potencia_pkg::*;
#(
  parameter int N_GRP = N_GRP_DEF,
  parameter int W_ACC = W_ACC_DEF
);
  localparam int W_IDX = $clog2(N_GRP);

  logic             rd_req;
  logic [W_IDX-1:0] rd_grp;
  logic             rd_valid;
  logic [W_ACC-1:0] rd_dato;
  logic             rd_sat;

  modport master (output rd_req, rd_grp, input rd_valid, rd_dato, rd_sat);
  modport slave  (input rd_req, rd_grp, output rd_valid, rd_dato, rd_sat);
endinterface

// File: rtl/acum_potencia_det_flancos.sv
// det_flancos: samples the monitored nets and produces per-channel rise and
// fall strobes, valid for the cycle after the edge that captured the new value.
//   clk, reset_L : clock and asynchronous active-low reset
//   sen          : monitored nets
//   sube         : 0->1 transition seen between the last two samples
//   baja         : 1->0 transition seen between the last two samples
module det_flancos
  import potencia_pkg::*;
#(
  parameter int N_CH = N_CH_DEF
) (
  input  logic            clk,
  input  logic            reset_L,
  input  logic [N_CH-1:0] sen,
  output logic [N_CH-1:0] sube,
  output logic [N_CH-1:0] baja
);

  logic [N_CH-1:0] s_q;
  logic [N_CH-1:0] s_prev;
  logic            armado;

  // On the first edge after reset s_q holds no real sample yet, so s_prev is
  // loaded with the same value s_q captures: the level present at reset
  // release never looks like a transition.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      s_q    <= '0;
      s_prev <= '0;
      armado <= 1'b0;
    end else begin
      s_q    <= sen;
      s_prev <= armado ? s_q : sen;
      armado <= 1'b1;
    end
  end

  assign sube = s_q & ~s_prev & {N_CH{armado}};
  assign baja = s_prev & ~s_q & {N_CH{armado}};

endmodule

// File: rtl/acum_potencia.sv
// acum_potencia: switching-power accumulator. Each clock, channels whose net
// toggled add their weight into the saturating accumulator of their group.
// Group totals are read through a one-cycle request/valid port that clears
// the group it reads (clear-on-read) without losing same-cycle increments.
//   clk, reset_L : clock and asynchronous active-low reset
//   sen          : monitored nets
//   peso         : channel i weight at [i*W_PESO +: W_PESO]
//   grupo        : channel i group at [i*$clog2(N_GRP) +: $clog2(N_GRP)]
//   habilitar    : accumulate when high; detection runs regardless
//   borrar       : synchronous clear of every group (wins over read-clear)
//   rd           : read port (acum_potencia_if.slave)
// Build option: define CUENTA_BAJADA_EN to also count 1->0 transitions.
// W_ACC must not exceed potencia_pkg::W_SAT_MAX.
module acum_potencia
  import potencia_pkg::*;
#(
  parameter int N_CH   = N_CH_DEF,
  parameter int N_GRP  = N_GRP_DEF,
  parameter int W_PESO = W_PESO_DEF,
  parameter int W_ACC  = W_ACC_DEF
) (
  input  logic                          clk,
  input  logic                          reset_L,
  input  logic [N_CH-1:0]               sen,
  input  logic [N_CH*W_PESO-1:0]        peso,
  input  logic [N_CH*$clog2(N_GRP)-1:0] grupo,
  input  logic                          habilitar,
  input  logic                          borrar,
  acum_potencia_if.slave                rd
);

  localparam int W_IDX = $clog2(N_GRP);
  localparam int W_INC = W_PESO + $clog2(N_CH) + 1;

`ifdef CUENTA_BAJADA_EN
  localparam bit CUENTA_BAJADA = 1'b1;
`else
  localparam bit CUENTA_BAJADA = 1'b0;
`endif

  logic [N_CH-1:0]    sube;
  logic [N_CH-1:0]    baja;
  logic [N_CH-1:0]    evento;
  logic [W_INC-1:0]   inc      [N_GRP];
  logic [W_SAT_MAX:0] r_suma   [N_GRP];
  logic [W_SAT_MAX:0] r_solo   [N_GRP];
  logic [W_ACC-1:0]   acc_q    [N_GRP];
  logic               sat_q    [N_GRP];

  det_flancos #(.N_CH(N_CH)) u_det (
    .clk     (clk),
    .reset_L (reset_L),
    .sen     (sen),
    .sube    (sube),
    .baja    (baja)
  );

  assign evento = sube | (CUENTA_BAJADA ? baja : '0);

  // Per-group weighted sum of this cycle's events; every channel may land in
  // the same group, which is what sizes W_INC.
  always_comb begin
    for (int g = 0; g < N_GRP; g++) begin
      inc[g] = '0;
      for (int i = 0; i < N_CH; i++) begin
        if (evento[i] && (grupo[i*W_IDX +: W_IDX] == W_IDX'(g)))
          inc[g] = inc[g] + W_INC'(peso[i*W_PESO +: W_PESO]);
      end
    end
  end

  // r_suma: running total plus increment; r_solo: increment alone, which is
  // what a group restarts from when it is read.
  always_comb begin
    for (int g = 0; g < N_GRP; g++) begin
      r_suma[g] = sat_add(W_SAT_MAX'(acc_q[g]), W_SAT_MAX'(inc[g]), W_ACC);
      r_solo[g] = sat_add('0, W_SAT_MAX'(inc[g]), W_ACC);
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int g = 0; g < N_GRP; g++) begin
        acc_q[g] <= '0;
        sat_q[g] <= 1'b0;
      end
      rd.rd_valid <= 1'b0;
      rd.rd_dato  <= '0;
      rd.rd_sat   <= 1'b0;
    end else begin
      rd.rd_valid <= rd.rd_req;
      if (rd.rd_req) begin
        rd.rd_dato <= acc_q[rd.rd_grp];
        rd.rd_sat  <= sat_q[rd.rd_grp];
      end
      for (int g = 0; g < N_GRP; g++) begin
        if (borrar) begin
          acc_q[g] <= '0;
          sat_q[g] <= 1'b0;
        end else if (rd.rd_req && (rd.rd_grp == W_IDX'(g))) begin
          acc_q[g] <= habilitar ? W_ACC'(r_solo[g]) : '0;
          sat_q[g] <= habilitar & r_solo[g][W_SAT_MAX];
        end else if (habilitar) begin
          acc_q[g] <= W_ACC'(r_suma[g]);
          sat_q[g] <= sat_q[g] | r_suma[g][W_SAT_MAX];
        end
      end
    end
  end

endmodule

// File: tb/tb_acum_potencia.sv
module tb_acum_potencia;

  localparam int N_CH   = 8;
  localparam int N_GRP  = 4;
  localparam int W_PESO = 4;
  localparam int W_ACC  = 8;
  localparam int W_IDX  = 2;

`ifdef CUENTA_BAJADA_EN
  localparam int MULT = 2;
`else
  localparam int MULT = 1;
`endif

  logic                     clk;
  logic                     reset_L;
  logic [N_CH-1:0]          sen;
  logic [N_CH*W_PESO-1:0]   peso;
  logic [N_CH*W_IDX-1:0]    grupo;
  logic                     habilitar;
  logic                     borrar;

  acum_potencia_if #(.N_GRP(N_GRP), .W_ACC(W_ACC)) rd_if ();

  acum_potencia #(
    .N_CH(N_CH), .N_GRP(N_GRP), .W_PESO(W_PESO), .W_ACC(W_ACC)
  ) dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .sen       (sen),
    .peso      (peso),
    .grupo     (grupo),
    .habilitar (habilitar),
    .borrar    (borrar),
    .rd        (rd_if)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  // scoreboard: {sat, dato} expected per read, in issue order
  logic [W_ACC:0] exp_q[$];
  string          name_q[$];
  logic           req_prev = 1'b0;

  // monitor
  always @(negedge clk) begin
    if (!reset_L) begin
      req_prev = 1'b0;
    end else begin
      checks++;
      if (rd_if.rd_valid !== req_prev) begin
        failures++;
        $display("FAIL rd_valid_timing: got %b, expected %b at %0t", rd_if.rd_valid, req_prev, $time);
      end
      if (rd_if.rd_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_read: got dato=%0d sat=%b with nothing expected", rd_if.rd_dato, rd_if.rd_sat);
        end else begin
          logic [W_ACC:0] e;
          string          n;
          e = exp_q.pop_front();
          n = name_q.pop_front();
          if ({rd_if.rd_sat, rd_if.rd_dato} !== e) begin
            failures++;
            $display("FAIL %s: got dato=%0d sat=%b, expected dato=%0d sat=%b",
                     n, rd_if.rd_dato, rd_if.rd_sat, e[W_ACC-1:0], e[W_ACC]);
          end
        end
      end
      req_prev = rd_if.rd_req;
    end
  end

  // driver tasks: every step starts #1 after a rising edge and drops the
  // single-cycle strobes from the previous step
  task automatic tick();
    @(posedge clk);
    #1;
    rd_if.rd_req = 1'b0;
    borrar       = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic leer(input int g, input int dato, input bit sat, input string n);
    tick();
    rd_if.rd_req = 1'b1;
    rd_if.rd_grp = W_IDX'(g);
    exp_q.push_back({sat, W_ACC'(dato)});
    name_q.push_back(n);
  endtask

  task automatic set_ch(input int i, input int w, input int g);
    peso[i*W_PESO +: W_PESO] = W_PESO'(w);
    grupo[i*W_IDX +: W_IDX]  = W_IDX'(g);
  endtask

  task automatic limpiar();
    tick();
    peso  = '0;
    grupo = '0;
    sen   = '0;
    ticks(3);
    borrar = 1'b1;
    ticks(2);
  endtask

  task automatic pulsos(input int ch, input int n);
    for (int k = 0; k < n; k++) begin
      tick(); sen[ch] = 1'b1;
      tick(); sen[ch] = 1'b0;
    end
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_L      = 1'b0;
    sen          = 8'hFF;
    peso         = '0;
    grupo        = '0;
    habilitar    = 1'b1;
    borrar       = 1'b0;
    rd_if.rd_req = 1'b0;
    rd_if.rd_grp = '0;
    ticks(3);
    reset_L = 1'b1;

    // level held through reset release is not a transition
    for (int g = 0; g < N_GRP; g++) set_ch(g, 15, g);
    ticks(10);
    leer(0, 0, 1'b0, "rst_g0");
    leer(1, 0, 1'b0, "rst_g1");
    leer(2, 0, 1'b0, "rst_g2");
    leer(3, 0, 1'b0, "rst_g3");

    // five pulses, weight 3
    limpiar();
    set_ch(0, 3, 0);
    pulsos(0, 5);
    ticks(3);
    leer(0, 15 * MULT, 1'b0, "pulses_w3");

    // all eight channels into group 2 in one cycle
    limpiar();
    for (int i = 0; i < N_CH; i++) set_ch(i, i + 1, 2);
    tick(); sen = 8'hFF;
    ticks(3);
    leer(2, 36, 1'b0, "all_ch_g2");
    leer(0, 0, 1'b0, "all_ch_g0");
    leer(1, 0, 1'b0, "all_ch_g1");
    leer(3, 0, 1'b0, "all_ch_g3");

    // saturation then immediate re-read
    limpiar();
    set_ch(1, 15, 1);
    pulsos(1, 20);
    ticks(3);
    leer(1, 255, 1'b1, "sat_read");
    leer(1, 0, 1'b0, "sat_reread");

    // read-clear racing an increment
    limpiar();
    set_ch(2, 10, 3);
    set_ch(3, 5, 3);
    tick(); sen[2] = 1'b1;
    ticks(3);
    sen[3] = 1'b1;
    leer(3, 10, 1'b0, "rdclr_race_first");
    ticks(3);
    leer(3, 5, 1'b0, "rdclr_race_second");

    // borrar with a read in the same cycle
    limpiar();
    set_ch(4, 7, 0);
    tick(); sen[4] = 1'b1;
    ticks(3);
    leer(0, 7, 1'b0, "borrar_read_pre");
    borrar = 1'b1;
    leer(0, 0, 1'b0, "borrar_read_post");

    // habilitar low: detection runs but nothing is kept
    limpiar();
    set_ch(6, 4, 2);
    habilitar = 1'b0;
    pulsos(6, 3);
    ticks(3);
    habilitar = 1'b1;
    leer(2, 0, 1'b0, "disabled");

    // single high-low pulse: 3, or 6 when falls count too
    limpiar();
    set_ch(5, 3, 1);
    pulsos(5, 1);
    ticks(3);
    leer(1, 3 * MULT, 1'b0, "edge_mode");

    // asynchronous reset while a read result is being presented
    limpiar();
    set_ch(6, 9, 2);
    tick(); sen[6] = 1'b1;
    ticks(3);
    leer(2, 9, 1'b0, "pre_reset_read");
    tick();
    @(negedge clk);
    #1;
    reset_L = 1'b0;
    #1;
    checks++;
    if ({rd_if.rd_valid, rd_if.rd_sat, rd_if.rd_dato} !== '0) begin
      failures++;
      $display("FAIL async_reset: got valid=%b sat=%b dato=%0d, expected all 0",
               rd_if.rd_valid, rd_if.rd_sat, rd_if.rd_dato);
    end
    ticks(2);
    reset_L = 1'b1;
    ticks(3);
    leer(2, 0, 1'b0, "post_reset_read");

    ticks(4);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL reads_outstanding: got %0d unanswered, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acum_potencia.md
# acum_potencia

Synthesizable, parametrised switching-power accumulator. Monitors `N_CH` nets each clock, detects 0→1 output transitions, and adds a per-channel power weight into one of `N_GRP` saturating group accumulators. It sits next to the gate library as the clocked, hardware-countable successor of the per-gate power-counter arrays kept in the testbench. Group totals are read through a one-cycle request/valid port with clear-on-read.

## Interface
- `N_CH`, 8, number of monitored nets
- `N_GRP`, 4, number of power groups (power of two, ≥2)
- `W_PESO`, 4, width of each channel weight
- `W_ACC`, 16, width of each group accumulator
- `clk` in 1: single clock, rising edge
- `reset_L` in 1: reset, asynchronous, active-low
- `sen` in `N_CH`: monitored nets, sampled every cycle
- `peso` in `N_CH*W_PESO`: channel i weight at `[i*W_PESO +: W_PESO]`, quasi-static
- `grupo` in `N_CH*$clog2(N_GRP)`: channel i group index, quasi-static
- `habilitar` in 1: accumulation enable
- `borrar` in 1: synchronous clear of all groups
- `rd_req` in 1: read request, one per cycle
- `rd_grp` in `$clog2(N_GRP)`: group to read
- `rd_valid` out 1: read data valid
- `rd_dato` out `W_ACC`: group total
- `rd_sat` out 1: group saturated since its last clear

## Operation
- Detector: `s_q <= sen` each edge; `armado` goes 1 on the first edge after reset. `sube = s_q & ~s_prev & {N_CH{armado}}`, where `s_prev` is the previous `s_q`. No transition is counted for the value captured at reset release.
- Per group g: `inc[g] = Σ peso[i]` over channels with `sube[i]` and `grupo[i]==g`.
  - `inc` width is `W_PESO+$clog2(N_CH)+1`.
  - All channels may hit one group in the same cycle.
- Update when `habilitar=1`: `acc[g] <= min(acc[g]+inc[g], 2^W_ACC-1)`. If the sum exceeds the maximum, sticky `sat[g]` is set.
- When `habilitar=0`, detection continues but increments are discarded. No deferred counting.
- Read: `rd_req` at edge r loads `rd_dato=acc[rd_grp]` and `rd_sat=sat[rd_grp]` with their pre-update values, and sets `rd_valid=1` for one cycle. The same edge clears that group to `inc[g]` (if enabled) and sets `sat[g]` to whether `inc` alone overflowed. No increment is lost.
- Back-to-back `rd_req` is allowed every cycle.
- `rd_valid=0` keeps the last `rd_dato`/`rd_sat`.
- `borrar`: all `acc`/`sat` go to 0 and the same-cycle increments are dropped. `borrar` overrides read-clear. A simultaneous `rd_req` still returns the pre-clear value.
- Reset (`reset_L=0`, any time) asynchronously zeroes: `s_q`, `s_prev`, `armado`, all `acc`, all `sat`, `rd_valid`, `rd_dato`, `rd_sat`.

## Timing
- `sen` rises before edge k → `s_q` at k → `acc` reflects it after edge k+1.
- Read latency: 1 cycle (`rd_req` at edge r → `rd_valid` high after r).
- Worst-case path: `N_CH`-input weighted adder plus saturate plus mux. Registered outputs only.

## Configuration
- `CUENTA_BAJADA_EN` defined: 1→0 transitions (`s_prev & ~s_q`) also add the channel weight, modelling both charge and discharge.
- `CUENTA_BAJADA_EN` undefined: only 0→1 transitions count, matching the gate library's power convention.

## Structure
- Package `potencia_pkg`: default widths, a `sat_add` function, and a `clog2`-based index-width constant.
- Sub-module `det_flancos`: sampling registers, `armado`, and rise/fall vectors, with `N_CH` as its parameter.
- The group adders, accumulators, and read port stay in the top.

## Test plan
- Reset released with `sen=8'hFF` held for 10 cycles → read of any group returns 0, `rd_sat=0`.
- ch0 `peso=3`, group 0; pulse `sen[0]` 0→1 five times → `rd_req`/`rd_grp=0` returns 15, `rd_valid` one cycle later.
- ch0–7 group 2 with weights 1..8; all rise in one cycle → group 2 reads 36. Groups 0, 1, 3 read 0.
- Saturation, with `W_ACC=8`:
  - ch1 `peso=15`, group 1, 20 rises → read gives 255, `rd_sat=1`.
  - Immediate second read gives 0, `rd_sat=0`.
- Concurrency:
  - Group 3 holds 10; `rd_req` on group 3 in the same cycle as a weight-5 rise → read returns 10, next read returns 5.
  - `borrar` with `rd_req` → read returns the pre-clear value, then 0.
- Reset during activity: `reset_L` pulled low mid-count → `rd_valid`/`rd_dato`/`rd_sat` go to 0 without a clock edge.
- Edge-mode check: one high-low pulse with weight 3 → reads 6 with `CUENTA_BAJADA_EN` defined, 3 without.
